// File: rtl/des_pkg.sv
// Shared DES constants for the round-function back half: S-box contents, P table,
// datapath widths and the S-box lookup helper.
package des_pkg;

  localparam int EXP_W    = 48;
  localparam int F_W      = 32;
  localparam int NUM_SBOX = 8;

  // Box j occupies SBOX[j]; entry {row,col} in row-major order.
  // Each 256-bit word lists one box, rows 0..3 left to right.
  localparam logic [0:7][0:63][3:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // 1-based DES bit numbers, as in the standard P table.
  localparam int P_TABLE [F_W] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // j is the zero-based box index (box j+1); six_bits[0] is b1, six_bits[5] is b6.
  function automatic logic [3:0] des_sbox_lookup(input logic [2:0] j,
                                                 input logic [5:0] six_bits);
    logic [5:0] idx;
    idx = {six_bits[0], six_bits[5], six_bits[1], six_bits[2], six_bits[3], six_bits[4]};
    return SBOX[j][idx];
  endfunction

endpackage

// File: rtl/des_sbox_perm.sv
// Combinational S-box substitution (i_x -> o_s) and P permutation (i_s -> o_f).
// The halves are separate so a register can sit between them (DES_SBOX_MIDREG_EN).
module des_sbox_perm
  import des_pkg::*;
(
  input  logic [EXP_W-1:0] i_x,
  output logic [F_W-1:0]   o_s,
  input  logic [F_W-1:0]   i_s,
  output logic [F_W-1:0]   o_f
);

  for (genvar j = 0; j < NUM_SBOX; j++) begin : g_sbox
    logic [3:0] w_nib;
    assign w_nib = des_sbox_lookup(3'(j), i_x[6*j +: 6]);
    // Nibble MSB lands on the lowest index (DES bit 4j+1).
    assign o_s[4*j +: 4] = {w_nib[0], w_nib[1], w_nib[2], w_nib[3]};
  end

  for (genvar k = 0; k < F_W; k++) begin : g_perm
    localparam int SRC = P_TABLE[k] - 1;
    assign o_f[k] = i_s[SRC[4:0]];
  end

endmodule

// File: rtl/des_sbox_stage.sv
// DES round-function back half: key XOR, S-boxes and P behind a valid/ready pipe.
// DES_SBOX_MIDREG_EN adds a register between the S-boxes and P (latency 2).
module des_sbox_stage
  import des_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [EXP_W-1:0] ExpIn,
  input  logic [EXP_W-1:0] KeyIn,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [F_W-1:0]   FOut,
  output logic [CNT_W-1:0] BlockCount
);

  logic             r_a_vld;
  logic [EXP_W-1:0] r_x;
  logic [CNT_W-1:0] r_cnt;
  logic             w_a_adv;
  logic             w_acc;
  logic             w_xfer;
  logic [F_W-1:0]   w_s;
  logic [F_W-1:0]   w_p_in;
  logic [F_W-1:0]   w_f;

  assign InReady = !r_a_vld || w_a_adv;
  assign w_acc   = InValid && InReady && !Flush;
  assign w_xfer  = OutValid && OutReady;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_a_vld <= 1'b0;
      r_x     <= '0;
    end else begin
      if (Flush)        r_a_vld <= 1'b0;
      else if (InReady) r_a_vld <= InValid;
      if (w_acc)        r_x     <= ExpIn ^ KeyIn;
    end
  end

`ifdef DES_SBOX_MIDREG_EN
  logic           r_b_vld;
  logic [F_W-1:0] r_s;
  logic           w_b_rdy;

  assign w_b_rdy = !r_b_vld || OutReady;
  assign w_a_adv = r_a_vld && w_b_rdy;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_b_vld <= 1'b0;
      r_s     <= '0;
    end else begin
      if (Flush)        r_b_vld <= 1'b0;
      else if (w_b_rdy) r_b_vld <= r_a_vld;
      if (w_a_adv)      r_s     <= w_s;
    end
  end

  assign w_p_in   = r_s;
  assign OutValid = r_b_vld;
`else
  assign w_a_adv  = r_a_vld && OutReady;
  assign w_p_in   = w_s;
  assign OutValid = r_a_vld;
`endif

  des_sbox_perm u_sbox_perm (
    .i_x (r_x),
    .o_s (w_s),
    .i_s (w_p_in),
    .o_f (w_f)
  );

  assign FOut = w_f;

  // Counts transfers even in a flush cycle; flush only drops queued blocks.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)     r_cnt <= '0;
    else if (w_xfer) r_cnt <= r_cnt + 1'b1;
  end

  assign BlockCount = r_cnt;

endmodule

// File: tb/tb_des_sbox_stage.sv
// Directed bench for des_sbox_stage with an independent DES-notation f model and scoreboard.
module tb_des_sbox_stage;

  localparam int CNT_W = 4;
`ifdef DES_SBOX_MIDREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [2047:0] SB = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };
  localparam int PT [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  logic             Clk = 1'b0;
  logic             ResetN = 1'b0;
  logic             Flush = 1'b0;
  logic             InValid = 1'b0;
  logic             InReady;
  logic [47:0]      ExpIn = '0;
  logic [47:0]      KeyIn = '0;
  logic             OutValid;
  logic             OutReady = 1'b0;
  logic [31:0]      FOut;
  logic [CNT_W-1:0] BlockCount;

  des_sbox_stage #(.CNT_W(CNT_W)) dut (
    .Clk(Clk), .ResetN(ResetN), .Flush(Flush),
    .InValid(InValid), .InReady(InReady), .ExpIn(ExpIn), .KeyIn(KeyIn),
    .OutValid(OutValid), .OutReady(OutReady), .FOut(FOut), .BlockCount(BlockCount)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] rev48(input logic [47:0] v);
    return {<<{v}};
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    return {<<{v}};
  endfunction

  // Textbook formulation: bit 1 is the MSB of every DES-notation vector.
  function automatic logic [31:0] ref_f(input logic [47:0] e, input logic [47:0] k);
    logic [47:0] xd;
    logic [31:0] sd, fd;
    logic [5:0]  six;
    int          ei;
    xd = rev48(e ^ k);
    for (int j = 0; j < 8; j++) begin
      six = xd[47-6*j -: 6];
      ei  = j*64 + 32*int'(six[5]) + 16*int'(six[0]) + int'(six[4:1]);
      sd[31-4*j -: 4] = SB[2047-4*ei -: 4];
    end
    for (int p = 1; p <= 32; p++) fd[32-p] = sd[32-PT[p-1]];
    return rev32(fd);
  endfunction

  // Scoreboard: predicts every transfer and the running block count.
  logic [31:0]      sb_q [$];
  logic [CNT_W-1:0] m_cnt = '0;

  always @(negedge Clk) begin
    if (!ResetN) begin
      sb_q.delete();
      m_cnt = '0;
    end else begin
      chk("cnt", 64'(BlockCount), 64'(m_cnt));
      if (OutValid && OutReady) begin
        if (sb_q.size() == 0) chk("spurious_out", 64'(OutValid), 64'(0));
        else                  chk("fout_order", 64'(FOut), 64'(sb_q.pop_front()));
        m_cnt = m_cnt + 1'b1;
      end
      if (Flush)                     sb_q.delete();
      else if (InValid && InReady)   sb_q.push_back(ref_f(ExpIn, KeyIn));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Offers one block and returns once OutValid rises (cycles from accept edge).
  task automatic send(input logic [47:0] e_des, input logic [47:0] k_des, output int lat);
    ExpIn = rev48(e_des);
    KeyIn = rev48(k_des);
    InValid = 1'b1;
    OutReady = 1'b1;
    tick();
    InValid = 1'b0;
    lat = 1;
    while (!OutValid && lat < 10) begin
      tick();
      lat++;
    end
  endtask

  // Fills the pipe with OutReady low; n = blocks accepted before InReady drops.
  task automatic fill(output int n);
    OutReady = 1'b0;
    InValid = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      ExpIn = {16'($urandom), $urandom};
      KeyIn = {16'($urandom), $urandom};
      #1;
      if (!InReady) break;
      n++;
      @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    int               lat, nfill, tot, run, best, stall;
    logic [31:0]      held;
    logic [CNT_W-1:0] c0;
    logic             any_vld;

    OutReady = 1'b1;
    #12;
    chk("rst_ovld", 64'(OutValid), 64'(0));
    chk("rst_cnt", 64'(BlockCount), 64'(0));
    @(posedge Clk); #1;
    ResetN = 1'b1;
    tick();
    chk("rst_inrdy", 64'(InReady), 64'(1));
    chk("rst_fout_known", 64'($isunknown(FOut)), 64'(0));

    // Worked DES example and all-zero input.
    send(48'h7A15557A1555, 48'h1B02EFFC7072, lat);
    chk("v1_lat", 64'(lat), 64'(LAT));
    chk("v1_fout", 64'(FOut), 64'(rev32(32'h234AA9BB)));
    tick();
    chk("v1_cnt", 64'(BlockCount), 64'(1));
    chk("v1_ovld_after", 64'(OutValid), 64'(0));
    send(48'h0, 48'h0, lat);
    chk("v2_lat", 64'(lat), 64'(LAT));
    chk("v2_fout", 64'(FOut), 64'(rev32(32'hD8D8DBBC)));
    tick();
    chk("v2_cnt", 64'(BlockCount), 64'(2));

    // 20 back-to-back blocks at full throughput.
    OutReady = 1'b1;
    tot = 0; run = 0; best = 0; stall = 0;
    for (int i = 0; i < 20 + LAT + 3; i++) begin
      if (i < 20) begin
        InValid = 1'b1;
        ExpIn = {16'($urandom), $urandom};
        KeyIn = {16'($urandom), $urandom};
        if (!InReady) stall++;
      end else begin
        InValid = 1'b0;
      end
      if (OutValid) begin
        tot++; run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
      tick();
    end
    chk("b2b_total", 64'(tot), 64'(20));
    chk("b2b_run", 64'(best), 64'(20));
    chk("b2b_stalls", 64'(stall), 64'(0));

    // Back-pressure with a full pipe.
    fill(nfill);
    chk("bp_depth", 64'(nfill), 64'(LAT));
    held = FOut;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_inrdy", 64'(InReady), 64'(0));
      chk("bp_ovld", 64'(OutValid), 64'(1));
      chk("bp_hold", 64'(FOut), 64'(held));
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) tick();
    tick();
    chk("bp_drained", 64'(sb_q.size()), 64'(0));
    chk("bp_ovld_end", 64'(OutValid), 64'(0));

    // Flush with stalled output: nothing transfers, nothing captured.
    fill(nfill);
    c0 = BlockCount;
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    InValid = 1'b0;
    chk("fl_ovld", 64'(OutValid), 64'(0));
    chk("fl_cnt", 64'(BlockCount), 64'(c0));
    OutReady = 1'b1;
    any_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      any_vld |= OutValid;
    end
    chk("fl_nocap", 64'(any_vld), 64'(0));

    // Flush while a transfer completes and InReady is high: transfer counted, input dropped.
    fill(nfill);
    c0 = BlockCount;
    OutReady = 1'b1;
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    InValid = 1'b0;
    chk("fl2_cnt", 64'(BlockCount), 64'(c0 + 1'b1));
    chk("fl2_ovld", 64'(OutValid), 64'(0));
    any_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      any_vld |= OutValid;
    end
    chk("fl2_nocap", 64'(any_vld), 64'(0));

    // Counter wrap at CNT_W=4.
    for (int i = 0; i < 40 && BlockCount != 4'hF; i++) begin
      send({16'($urandom), $urandom}, {16'($urandom), $urandom}, lat);
      tick();
    end
    chk("wrap_max", 64'(BlockCount), 64'(4'hF));
    send(48'h123456789ABC, 48'hFEDCBA987654, lat);
    tick();
    chk("wrap_zero", 64'(BlockCount), 64'(0));

    // Asynchronous reset mid-stream.
    OutReady = 1'b1;
    InValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ExpIn = {16'($urandom), $urandom};
      KeyIn = {16'($urandom), $urandom};
      tick();
    end
    OutReady = 1'b0;
    tick();
    chk("pre_arst_cnt_nz", 64'(BlockCount != 0), 64'(1));
    chk("pre_arst_ovld", 64'(OutValid), 64'(1));
    #2;
    ResetN = 1'b0;
    #1;
    chk("arst_ovld", 64'(OutValid), 64'(0));
    chk("arst_cnt", 64'(BlockCount), 64'(0));
    InValid = 1'b0;
    tick();
    ResetN = 1'b1;
    tick();
    chk("post_arst_inrdy", 64'(InReady), 64'(1));
    chk("post_arst_ovld", 64'(OutValid), 64'(0));
    tick();
    chk("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
